unary_accum_nch: RTL and testbench



---
 rtl/unary_accum_nch_if.sv | 25 ++
 rtl/unary_accum_nch.sv | 103 ++++++++++
 tb/tb_unary_accum_nch.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/unary_accum_nch_if.sv
// Bus bundle for the unary pulse-count accumulator: control, unary lanes and registered results.
// The master drives control and lanes; the slave (the accumulator) returns the registered outputs.
interface unary_accum_nch_if #(
  parameter int NCH = 4,
  parameter int CW  = 4
);
  logic           en;
  logic           clr;
  logic           mode;
  logic [NCH-1:0] din;
  logic           dout;
  logic           carry;
  logic           done;
  logic [CW-1:0]  count;

  modport master (
    output en, clr, mode, din,
    input  dout, carry, done, count
  );

  modport slave (
    input  en, clr, mode, din,
    output dout, carry, done, count
  );
endinterface

// File: rtl/unary_accum_nch.sv
// Unary pulse-count accumulator: sums the 1s on NCH lanes into a modulo-MOD (or saturating)
// counter, and drains the stored count as a run of 1s on dout.
module unary_accum_nch #(
  parameter int NCH = 4,
  parameter int MOD = 15,
  parameter bit SAT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  unary_accum_nch_if.slave  bus
);
  localparam int CW = $clog2(MOD);
  localparam int SW = CW + 1;
  localparam int OW = $clog2(NCH + 1);

  typedef enum logic {
    MODE_ACCUM = 1'b0,
    MODE_DRAIN = 1'b1
  } mode_e;

  logic [CW-1:0] count_q, count_d;
  logic          dout_q, dout_d;
  logic          carry_q, carry_d;
  logic          done_q, done_d;

  logic [OW-1:0] ones;
  logic [SW-1:0] sum;
  mode_e         mode;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    ones = '0;
    for (int i = 0; i < NCH; i++) begin
      ones = ones + OW'(bus.din[i]);
    end
  end

  // One extra bit so count + ones never truncates before the modulus compare.
  assign sum = {1'b0, count_q} + SW'(ones);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    count_d = count_q;
    dout_d  = 1'b0;
    carry_d = 1'b0;
    done_d  = 1'b0;

    unique case (mode)
      MODE_ACCUM: begin
        if (SAT) begin
          if (sum > SW'(MOD - 1)) begin
            count_d = CW'(MOD - 1);
            carry_d = 1'b1;
          end else begin
            count_d = sum[CW-1:0];
          end
        end else begin
          // NCH < MOD guarantees at most one wrap per cycle.
          if (sum >= SW'(MOD)) begin
            count_d = CW'(sum - SW'(MOD));
            carry_d = 1'b1;
          end else begin
            count_d = sum[CW-1:0];
          end
        end
      end
      MODE_DRAIN: begin
        if (count_q != '0) begin
          count_d = count_q - CW'(1);
          dout_d  = 1'b1;
          done_d  = (count_q == CW'(1));
        end
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dout_q  <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.clr) begin
      count_q <= '0;
      dout_q  <= 1'b0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.en) begin
      count_q <= count_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.dout  = dout_q;
  assign bus.carry = carry_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_unary_accum_nch.sv
// Directed bench for unary_accum_nch: a wrapping and a saturating instance share one stimulus
// stream; expected values are hand-derived, plus a small popcount model for random sequences.
module tb_unary_accum_nch;
  localparam int NCH = 4;
  localparam int MOD = 15;
  localparam int CW  = $clog2(MOD);

  logic           clk;
  logic           rst_n;
  logic           en;
  logic           clr;
  logic           mode;
  logic [NCH-1:0] din;

  int errors;
  int checks;

  unary_accum_nch_if #(.NCH(NCH), .CW(CW)) bus_w ();
  unary_accum_nch_if #(.NCH(NCH), .CW(CW)) bus_s ();

  assign bus_w.en   = en;
  assign bus_w.clr  = clr;
  assign bus_w.mode = mode;
  assign bus_w.din  = din;
  assign bus_s.en   = en;
  assign bus_s.clr  = clr;
  assign bus_s.mode = mode;
  assign bus_s.din  = din;

  unary_accum_nch #(.NCH(NCH), .MOD(MOD), .SAT(1'b0)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w.slave)
  );

  unary_accum_nch #(.NCH(NCH), .MOD(MOD), .SAT(1'b1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v);
    int rem;
    clr  = 1'b1;
    en   = 1'b1;
    mode = 1'b0;
    din  = '0;
    step();
    clr = 1'b0;
    rem = v;
    while (rem > 0) begin
      din = (rem >= NCH) ? 4'b1111 : 4'((1 << rem) - 1);
      rem = (rem >= NCH) ? rem - NCH : 0;
      step();
    end
    din = '0;
  endtask

  initial begin
    int exp_dout[7];
    int mw, ms, cw_exp, cs_exp, pop;
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    mode  = 1'b0;
    din   = '0;
    #12;
    check("reset_count", int'(bus_w.count), 0);
    check("reset_outs", int'({bus_w.dout, bus_w.carry, bus_w.done}), 0);
    rst_n = 1'b1;
    step();

    // Wrap / saturate from 13 with +2.
    load(13);
    check("load13_w", int'(bus_w.count), 13);
    din = 4'b0011;
    step();
    check("wrap13_count_w", int'(bus_w.count), 0);
    check("wrap13_carry_w", int'(bus_w.carry), 1);
    check("sat13_count_s", int'(bus_s.count), 14);
    check("sat13_carry_s", int'(bus_s.carry), 1);

    // Hold with en=0 keeps carry high and count fixed.
    en  = 1'b0;
    din = 4'b1111;
    repeat (3) step();
    check("hold_count_w", int'(bus_w.count), 0);
    check("hold_carry_w", int'(bus_w.carry), 1);
    check("hold_count_s", int'(bus_s.count), 14);

    // From 14 with +4.
    load(14);
    din = 4'b1111;
    step();
    check("wrap14_count_w", int'(bus_w.count), 3);
    check("wrap14_carry_w", int'(bus_w.carry), 1);
    check("sat14_count_s", int'(bus_s.count), 14);
    check("sat14_carry_s", int'(bus_s.carry), 1);

    // From 12 with +4, then +0.
    load(12);
    din = 4'b1111;
    step();
    check("sat12_count_s", int'(bus_s.count), 14);
    check("sat12_carry_s", int'(bus_s.carry), 1);
    check("wrap12_count_w", int'(bus_w.count), 1);
    din = 4'b0000;
    step();
    check("sat12b_count_s", int'(bus_s.count), 14);
    check("sat12b_carry_s", int'(bus_s.carry), 0);
    check("wrap12b_carry_w", int'(bus_w.carry), 0);

    // Drain 5 over 7 cycles; din is ignored while draining.
    load(5);
    exp_dout = '{1, 1, 1, 1, 1, 0, 0};
    mode = 1'b1;
    din  = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("drain_dout%0d", i), int'(bus_w.dout), exp_dout[i]);
      check($sformatf("drain_done%0d", i), int'(bus_w.done), (i == 4) ? 1 : 0);
      check($sformatf("drain_carry%0d", i), int'(bus_w.carry), 0);
    end
    check("drain_end_count", int'(bus_w.count), 0);

    // Hold mid-drain keeps dout and done registered values.
    load(3);
    mode = 1'b1;
    step();
    step();
    step();
    en = 1'b0;
    repeat (2) step();
    check("hold_dout", int'(bus_w.dout), 1);
    check("hold_done", int'(bus_w.done), 1);
    check("hold_drain_count", int'(bus_w.count), 0);

    // Clear with en=0 still clears.
    load(7);
    en   = 1'b0;
    din  = 4'b1111;
    repeat (3) step();
    check("hold7_count", int'(bus_w.count), 7);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_en0_count", int'(bus_w.count), 0);

    // Partial drain then accumulate onto the remainder.
    load(6);
    mode = 1'b1;
    repeat (2) step();
    check("partial_count", int'(bus_w.count), 4);
    mode = 1'b0;
    din  = 4'b0111;
    step();
    check("partial_accum", int'(bus_w.count), 7);
    check("partial_dout", int'(bus_w.dout), 0);

    // Async reset mid-drain, between clock edges.
    load(11);
    mode = 1'b1;
    repeat (2) step();
    check("pre_rst_count", int'(bus_w.count), 9);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_count", int'(bus_w.count), 0);
    check("async_rst_outs", int'({bus_w.dout, bus_w.carry, bus_w.done}), 0);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_dout", int'(bus_w.dout), 0);
    check("post_rst_done", int'(bus_w.done), 0);

    // Random popcount sequences with random enable.
    load(0);
    mw = 0;
    ms = 0;
    cw_exp = 0;
    cs_exp = 0;
    for (int i = 0; i < 60; i++) begin
      din = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 3) != 0);
      pop = int'(din[0]) + int'(din[1]) + int'(din[2]) + int'(din[3]);
      if (en) begin
        cw_exp = (mw + pop >= MOD) ? 1 : 0;
        mw     = (mw + pop) % MOD;
        cs_exp = (ms + pop > MOD - 1) ? 1 : 0;
        ms     = (ms + pop > MOD - 1) ? MOD - 1 : ms + pop;
      end
      step();
      check($sformatf("rnd_count_w%0d", i), int'(bus_w.count), mw);
      check($sformatf("rnd_carry_w%0d", i), int'(bus_w.carry), cw_exp);
      check($sformatf("rnd_count_s%0d", i), int'(bus_s.count), ms);
      check($sformatf("rnd_carry_s%0d", i), int'(bus_s.carry), cs_exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
